// File: rtl/nr_div_pkg.sv
// nr_div_pkg: FSM states, counter width and default Q-format constants for the NR divider
package nr_div_pkg;
  typedef enum logic [2:0] {IDLE, STEP1, STEP2, MULT, DONE} state_e;
  localparam int CNT_W    = 8;
  localparam int DEF_W    = 16;
  localparam int DEF_FRAC = 10;
endpackage

// File: rtl/nr_div_mulshift.sv
// nr_div_mulshift: signed (bias +/- a*b) >>> FRAC, then truncate or saturate to W bits
module nr_div_mulshift #(
  parameter int W    = 16,
  parameter int FRAC = 10,
  parameter bit NEG  = 1'b0,
  parameter bit SAT  = 1'b0
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [2*W:0] bias_i,
  output logic signed [W-1:0] y_o
);
  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  logic signed [2*W:0] prod, sum, shf;
  // full-precision product, bias, arithmetic shift and optional clamp to the signed W-bit range
  always_comb begin
    prod = $signed({{(W+1){a_i[W-1]}}, a_i}) * $signed({{(W+1){b_i[W-1]}}, b_i});
    sum  = NEG ? bias_i - prod : bias_i + prod;
    shf  = sum >>> FRAC;
    y_o  = !SAT ? shf[W-1:0] : shf > MAXV ? MAXV[W-1:0] : shf < MINV ? MINV[W-1:0] : shf[W-1:0];
  end
endmodule

// File: rtl/nr_divider_par.sv
// nr_divider_par: Newton-Raphson fixed-point divider; NR_DIVIDER_EARLY_EXIT_EN stops once x converges
module nr_divider_par
  import nr_div_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int MAX_ITER = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] nr,
  input  logic signed [W-1:0] dr,
  input  logic signed [W-1:0] initial_guess,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] quotient,
  output logic                div_by_zero,
  output logic [CNT_W-1:0]    iter_count
);
  localparam logic signed [2*W:0] TWO_Q = (2*W+1)'(2) << (2*FRAC);
  localparam logic signed [W-1:0] QMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] QMIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] ZERO  = '0;
  state_e             state_q;
  logic signed [W-1:0] nr_q, dr_q, x_q, t_q, quot_q;
  logic signed [W-1:0] t_d, x_d, quot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dbz_q, rdy_q, vld_q, stop;

  nr_div_mulshift #(.W(W), .FRAC(FRAC), .NEG(1'b1), .SAT(1'b0)) u_step1 (
    .a_i(dr_q), .b_i(x_q), .bias_i(TWO_Q), .y_o(t_d));
  nr_div_mulshift #(.W(W), .FRAC(FRAC), .NEG(1'b0), .SAT(1'b0)) u_step2 (
    .a_i(x_q), .b_i(t_q), .bias_i(ZERO), .y_o(x_d));
  nr_div_mulshift #(.W(W), .FRAC(FRAC), .NEG(1'b0), .SAT(1'b1)) u_mult (
    .a_i(nr_q), .b_i(x_q), .bias_i(ZERO), .y_o(quot_d));

  assign cnt_d = cnt_q + 1'b1;
`ifdef NR_DIVIDER_EARLY_EXIT_EN
  assign stop = (cnt_d == CNT_W'(MAX_ITER)) || (x_d == x_q);
`else
  assign stop = cnt_d == CNT_W'(MAX_ITER);
`endif

  // handshake FSM: accept, alternate STEP1/STEP2 per iteration, scale by nr, hold result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      nr_q    <= '0;
      dr_q    <= '0;
      x_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          nr_q  <= nr;
          dr_q  <= dr;
          x_q   <= initial_guess;
          cnt_q <= '0;
          rdy_q <= 1'b0;
          dbz_q <= dr == '0;
          if (dr == '0) begin
            quot_q  <= nr[W-1] ? QMIN : QMAX;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= STEP1;
          end
        end
        STEP1: begin
          t_q     <= t_d;
          state_q <= STEP2;
        end
        STEP2: begin
          x_q     <= x_d;
          cnt_q   <= cnt_d;
          state_q <= stop ? MULT : STEP1;
        end
        MULT: begin
          quot_q  <= quot_d;
          vld_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = vld_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign iter_count  = cnt_q;
endmodule

// File: tb/tb_nr_divider_par.sv
// tb_nr_divider_par: scoreboard bench for nr_divider_par (honours NR_DIVIDER_EARLY_EXIT_EN)
module tb_nr_divider_par;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic signed [15:0] nr, dr, initial_guess, quotient;
  logic [7:0] iter_count;
  int total = 0, bad = 0;
`ifdef NR_DIVIDER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  typedef struct {longint q; longint dbz; longint it; longint lat; bit tol;} exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  nr_divider_par dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .nr(nr), .dr(dr), .initial_guess(initial_guess),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .div_by_zero(div_by_zero), .iter_count(iter_count));

  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic longint tr(input longint v);
    logic signed [15:0] s;
    s = v[15:0];
    return longint'(s);
  endfunction

  function automatic void model(input longint n, input longint d, input longint g,
                                output longint q, output int it);
    longint x, t, xn, p;
    bit conv;
    it = 0;
    if (d == 0) begin
      q = n >= 0 ? 32767 : -32768;
      return;
    end
    x = g;
    forever begin
      t    = tr(((longint'(1) << 21) - d * x) >>> 10);
      xn   = tr((x * t) >>> 10);
      it++;
      conv = xn == x;
      x    = xn;
      if (it == 8 || (EE && conv)) break;
    end
    p = (n * x) >>> 10;
    q = p > 32767 ? 32767 : p < -32768 ? -32768 : p;
  endfunction

  task automatic send(input longint n, input longint d, input longint g, input bit use_q,
                      input longint qx, input bit tol, input int hold);
    exp_t e;
    longint mq, q0;
    int mit, edges;
    model(n, d, g, mq, mit);
    e.q   = use_q ? qx : mq;
    e.dbz = d == 0;
    e.it  = mit;
    e.lat = d == 0 ? 1 : 2 * mit + 2;
    e.tol = tol;
    @(negedge clk);
    nr = n[15:0];
    dr = d[15:0];
    initial_guess = g[15:0];
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    sbq.push_back(e);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1 edges++;
    end
    chk("valid_seen", out_valid, 1);
    e = sbq.pop_front();
    if (e.tol) chk("quot_tol", longint'(quotient >= e.q - 1 && quotient <= e.q + 1), 1);
    else chk("quotient", quotient, e.q);
    chk("div_by_zero", div_by_zero, e.dbz);
    chk("iter_count", iter_count, e.it);
    chk("latency", edges, e.lat);
    chk("in_ready_done", in_ready, 0);
    q0 = quotient;
    repeat (hold) begin
      @(posedge clk);
      #1 chk("hold_quot", quotient, q0);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_iter", iter_count, e.it);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("drop_valid", out_valid, 0);
    chk("back_idle", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    nr = '0; dr = '0; initial_guess = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst_quot", quotient, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_ready", in_ready, 1);
    send(3072, 1024, 1024, 1, 3072, 0, 0);
    send(1024, 2048, 410, 1, 512, 1, 0);
    send(-3072, 1024, 1024, 1, -3072, 0, 0);
    send(5000, 0, 0, 1, 32767, 0, 0);
    send(-4000, 0, 77, 1, -32768, 0, 0);
    send(30720, 103, 10240, 1, 32767, 0, 5);
    send(5120, 1536, 600, 0, 0, 0, 1);
    send(-7000, -3000, -300, 0, 0, 0, 0);
    @(negedge clk);
    nr = 16'sd1000; dr = 16'sd1024; initial_guess = 16'sd1024; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    @(posedge clk);
    #1 chk("abort_valid_next", out_valid, 0);
    chk("abort_ready_next", in_ready, 1);
    chk("abort_iter", iter_count, 0);
    @(negedge clk) rst = 1'b0;
    send(2048, 1024, 1024, 1, 2048, 0, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nr_divider_par.md
NR_DIVIDER_PAR -- requirements
Module: nr_divider_par

Interface
REQ-001 SHALL expose parameter W, default 16: operand and result width, two's-complement fixed point.
REQ-002 SHALL expose parameter FRAC, default 10: fractional bits of the Q format (1.0 = 2^FRAC).
REQ-003 SHALL expose parameter MAX_ITER, default 8: Newton-Raphson iteration limit, range 1..255.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block accepts a request.
REQ-008 nr  in  W  signed numerator.
REQ-009 dr  in  W  signed divisor.
REQ-010 initial_guess  in  W  signed seed for 1/dr.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 quotient  out  W  signed nr/dr in Q format.
REQ-014 div_by_zero  out  1  dr was zero.
REQ-015 iter_count  out  8  iterations performed for this result.

Function
REQ-016 SHALL implement FSM states IDLE, STEP1, STEP2, MULT, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an accept (in_valid && in_ready) SHALL latch nr, dr, initial_guess into x and go to STEP1.
REQ-018 An accept with dr == 0 SHALL go directly to DONE with div_by_zero=1, iter_count=0, quotient = 2^(W-1)-1 if nr >= 0 and -2^(W-1) if nr < 0.
REQ-019 STEP1 SHALL register t = ((2 << 2*FRAC) - dr*x) >>> FRAC, with the product in 2W+1 bits and t truncated to W bits.
REQ-020 STEP2 SHALL register x_next = (x*t) >>> FRAC, truncated to W bits, and increment the iteration counter.
REQ-021 STEP2 SHALL go to MULT when the counter reaches MAX_ITER, otherwise to STEP1.
REQ-022 MULT SHALL compute (nr*x) >>> FRAC in 2W bits, saturate it to the signed W-bit range, register it into quotient, and go to DONE.
REQ-023 out_valid SHALL be 1 only in DONE; quotient, div_by_zero and iter_count SHALL be stable while out_valid=1.
REQ-024 DONE with out_ready=1 SHALL go to IDLE next cycle; no new request is accepted in that same cycle.
REQ-025 Without early exit, out_valid SHALL rise exactly 2*MAX_ITER+2 clock edges after the accept edge.
REQ-026 All shifts SHALL be arithmetic; the block SHALL not round.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, abandon any transaction in flight, and set quotient=0, div_by_zero=0, iter_count=0, out_valid=0 and internal x, t and counter to 0.
REQ-028 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-029 With NR_DIVIDER_EARLY_EXIT_EN defined, STEP2 SHALL go to MULT when x_next == x or the counter reaches MAX_ITER, whichever comes first; iter_count SHALL report the actual count.
REQ-030 Without NR_DIVIDER_EARLY_EXIT_EN, the block SHALL always run MAX_ITER iterations.

Structure
REQ-031 Package nr_div_pkg SHALL hold the FSM state enum, the counter width constant (8) and the default Q-format constants.
REQ-032 Sub-module nr_div_mulshift SHALL be a combinational signed multiply, then arithmetic shift by FRAC, then truncate/saturate option; it is instantiated for STEP1, STEP2 and MULT.

Verification (W=16, FRAC=10, MAX_ITER=8)
REQ-033 nr=3072, dr=1024, guess=1024 -> quotient=3072, div_by_zero=0; iter_count=1 with the macro, 8 without; without the macro out_valid occurs 18 edges after accept.
REQ-034 nr=1024, dr=2048, guess=410 -> quotient=512 ±1.
REQ-035 nr=-3072, dr=1024, guess=1024 -> quotient=-3072; with nr=5000, dr=0 -> quotient=32767, div_by_zero=1, out_valid 1 edge after accept.
REQ-036 nr=30720, dr=103, guess=10240 -> quotient saturates to 32767; hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-037 Assert rst during STEP2 of a transaction -> next cycle out_valid=0 and in_ready=1; a following request nr=2048, dr=1024, guess=1024 -> quotient=2048.
